// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline sequencing controller of the 5-stage core.
//   - sequencer state encoding (visible on state_o for debug)
//   - stall vector bit indices, width and canned stall patterns
//   - reset level and the hard-wired zero register address
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  // Stall vector layout: one hold enable per pipeline register.
  localparam int STALL_W     = 6;
  localparam int STALL_PC    = 0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_WB    = 4;
  localparam int STALL_RSV   = 5;  // reserved, always driven 0

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t ZeroStall = '0;

  // Load-use: hold PC and IF/ID so the consumer waits in ID.
  localparam stall_bus_t StallFrontEnd =
    stall_bus_t'((1 << STALL_PC) | (1 << STALL_IF_ID));

  // Multi-cycle EXE: freeze everything up to and including EXE/MEM.
  localparam stall_bus_t StallThroughExe =
    stall_bus_t'((1 << STALL_PC) | (1 << STALL_IF_ID) |
                 (1 << STALL_ID_EX) | (1 << STALL_EX_MEM));

  localparam logic       RstEnable   = 1'b1;
  localparam logic [4:0] ZeroRegAddr = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MC_WAIT  = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_detect
// Purely combinational load-use compare between the register reads of the
// instruction in ID and the destination of a load sitting in EXE.
// Ports:
//   id_rs1_en_i / id_rs1_addr_i : ID reads rs1, and its address
//   id_rs2_en_i / id_rs2_addr_i : ID reads rs2, and its address
//   ex_wreg_i / ex_rd_addr_i    : EXE writes rd, and its address
//   ex_is_load_i                : EXE instruction is a load
//   lu_hazard_o                 : ID consumes the load result next cycle
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       id_rs1_en_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic       id_rs2_en_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       ex_wreg_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_is_load_i,
  output logic       lu_hazard_o
);

  logic w_ld_writes;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never produces a value
  // anyone can wait for.
  assign w_ld_writes = ex_is_load_i & ex_wreg_i & (ex_rd_addr_i != ZeroRegAddr);
  assign w_rs1_hit   = id_rs1_en_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign w_rs2_hit   = id_rs2_en_i & (id_rs2_addr_i == ex_rd_addr_i);

  assign lu_hazard_o = w_ld_writes & (w_rs1_hit | w_rs2_hit);

endmodule : pipe_hazard_ctrl_hazard_detect

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Single source of stall and flush for every pipeline register of the 5-stage
// core. Handles taken branches (flush), multi-cycle EXE operations (freeze for
// exactly N cycles) and load-use hazards (one bubble). Outputs respond in the
// same cycle as the triggering inputs; only the state and the multi-cycle
// down-counter are registered.
// Ports:
//   clk, rst              : core clock, asynchronous active-high reset
//   id_rs1_* / id_rs2_*   : register reads of the instruction in ID
//   ex_wreg_i, ex_rd_addr_i, ex_is_load_i : destination/type of EXE instruction
//   ex_mc_start_i, ex_mc_cycles_i : multi-cycle op start pulse and its length
//   ex_branch_taken_i     : EXE resolved a taken branch/jump
//   stall_o               : per-stage hold enables (bit0 PC .. bit4 MEM/WB)
//   flush_if_id_o         : load NOP into IF/ID
//   flush_id_exe_o        : load NOP into ID/EXE
//   busy_o, state_o       : sequencer not in RUN, and raw state (debug)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STALL_W  = pipe_hazard_ctrl_pkg::STALL_W,
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_rs1_en_i,
  input  logic [4:0]          id_rs1_addr_i,
  input  logic                id_rs2_en_i,
  input  logic [4:0]          id_rs2_addr_i,
  input  logic                ex_wreg_i,
  input  logic [4:0]          ex_rd_addr_i,
  input  logic                ex_is_load_i,
  input  logic                ex_mc_start_i,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles_i,
  input  logic                ex_branch_taken_i,
  output logic [STALL_W-1:0]  stall_o,
  output logic                flush_if_id_o,
  output logic                flush_id_exe_o,
  output logic                busy_o,
  output logic [1:0]          state_o
);

  localparam logic [STALL_W-1:0] LP_STALL_NONE = STALL_W'(ZeroStall);
  localparam logic [STALL_W-1:0] LP_STALL_LU   = STALL_W'(StallFrontEnd);
  localparam logic [STALL_W-1:0] LP_STALL_MC   = STALL_W'(StallThroughExe);
  localparam logic [MC_CNT_W-1:0] LP_CNT_ONE   = MC_CNT_W'(1);

  state_t              r_state;
  logic [MC_CNT_W-1:0] r_mc_cnt;

  state_t              w_next_state;
  logic [MC_CNT_W-1:0] w_next_cnt;
  logic [MC_CNT_W-1:0] w_mc_len;
  logic [STALL_W-1:0]  w_stall;
  logic                w_flush_if_id;
  logic                w_flush_id_exe;
  logic                w_lu_hazard;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .id_rs1_en_i   (id_rs1_en_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_en_i   (id_rs2_en_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .ex_wreg_i     (ex_wreg_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_is_load_i  (ex_is_load_i),
    .lu_hazard_o   (w_lu_hazard)
  );

  // A zero-length request still occupies EXE for its start cycle.
  assign w_mc_len = (ex_mc_cycles_i == '0) ? LP_CNT_ONE : ex_mc_cycles_i;

  // NOTE: every signal written here gets a default at the top of the block,
  // so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_mc_cnt;
    w_stall        = LP_STALL_NONE;
    w_flush_if_id  = 1'b0;
    w_flush_id_exe = 1'b0;

    case (r_state)
      ST_RUN: begin
        // Priority branch > multi-cycle > load-use; a dropped lower-priority
        // event is seen again when its instruction comes back around.
        if (ex_branch_taken_i) begin
          w_flush_if_id  = 1'b1;
          w_flush_id_exe = 1'b1;
          w_next_state   = ST_FLUSH;
        end else if (ex_mc_start_i) begin
          w_stall = LP_STALL_MC;
          if (w_mc_len != LP_CNT_ONE) begin
            // Start cycle counts as the first of the N stalled cycles.
            w_next_cnt   = w_mc_len - LP_CNT_ONE;
            w_next_state = ST_MC_WAIT;
          end
        end else if (w_lu_hazard) begin
          w_stall        = LP_STALL_LU;
          w_flush_id_exe = 1'b1;
          w_next_state   = ST_LU_STALL;
        end
      end

      // The load has moved on to MEM; the re-presented ID instruction is
      // now satisfied by forwarding, so no detection this cycle.
      ST_LU_STALL: w_next_state = ST_RUN;

      // EXE is frozen: all ex_*/id_* inputs are stale and ignored.
      ST_MC_WAIT: begin
        w_stall = LP_STALL_MC;
        if (r_mc_cnt <= LP_CNT_ONE) begin
          w_next_cnt   = '0;
          w_next_state = ST_RUN;
        end else begin
          w_next_cnt = r_mc_cnt - LP_CNT_ONE;
        end
      end

      // ID holds the bubble injected by the flush; nothing to detect.
      ST_FLUSH: w_next_state = ST_RUN;

      default: w_next_state = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_mc_cnt <= w_next_cnt;
    end
  end

  // Reset gates the combinational terms so nothing leaks out while asserted.
  assign stall_o        = rst ? LP_STALL_NONE : w_stall;
  assign flush_if_id_o  = rst ? 1'b0 : w_flush_if_id;
  assign flush_id_exe_o = rst ? 1'b0 : w_flush_id_exe;
  assign busy_o         = rst ? 1'b0 : (r_state != ST_RUN);
  assign state_o        = r_state;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Scoreboard bench: the driver applies one input vector per cycle, asks a
// behavioural model for the expected response and queues it; a monitor on the
// falling edge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MC_CNT_W = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                id_rs1_en_i = 1'b0;
  logic [4:0]          id_rs1_addr_i = '0;
  logic                id_rs2_en_i = 1'b0;
  logic [4:0]          id_rs2_addr_i = '0;
  logic                ex_wreg_i = 1'b0;
  logic [4:0]          ex_rd_addr_i = '0;
  logic                ex_is_load_i = 1'b0;
  logic                ex_mc_start_i = 1'b0;
  logic [MC_CNT_W-1:0] ex_mc_cycles_i = '0;
  logic                ex_branch_taken_i = 1'b0;
  logic [5:0]          stall_o;
  logic                flush_if_id_o;
  logic                flush_id_exe_o;
  logic                busy_o;
  logic [1:0]          state_o;

  pipe_hazard_ctrl #(.STALL_W(6), .MC_CNT_W(MC_CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs1_en_i       (id_rs1_en_i),
    .id_rs1_addr_i     (id_rs1_addr_i),
    .id_rs2_en_i       (id_rs2_en_i),
    .id_rs2_addr_i     (id_rs2_addr_i),
    .ex_wreg_i         (ex_wreg_i),
    .ex_rd_addr_i      (ex_rd_addr_i),
    .ex_is_load_i      (ex_is_load_i),
    .ex_mc_start_i     (ex_mc_start_i),
    .ex_mc_cycles_i    (ex_mc_cycles_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .stall_o           (stall_o),
    .flush_if_id_o     (flush_if_id_o),
    .flush_id_exe_o    (flush_id_exe_o),
    .busy_o            (busy_o),
    .state_o           (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] stall;
    logic       fl_if_id;
    logic       fl_id_exe;
    logic       busy;
    logic [1:0] st;
  } resp_t;

  resp_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Model: how many more frozen cycles remain, and whether the next cycle is
  // the single dead cycle after a load-use bubble or a branch flush.
  int m_mc_left  = 0;
  bit m_after_lu = 1'b0;
  bit m_after_br = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mc_left  = 0;
    m_after_lu = 1'b0;
    m_after_br = 1'b0;
  endtask

  function automatic resp_t model_step(
    input logic rs1_en, input logic [4:0] rs1, input logic rs2_en, input logic [4:0] rs2,
    input logic wreg, input logic [4:0] rd, input logic ld, input logic mc,
    input logic [MC_CNT_W-1:0] cyc, input logic br);
    resp_t e;
    int    n;
    bit    hz;
    e = '0;
    if (m_mc_left > 0) begin
      e.stall = 6'b001111; e.busy = 1'b1; e.st = 2'd2;
      m_mc_left--;
    end else if (m_after_lu) begin
      e.busy = 1'b1; e.st = 2'd1; m_after_lu = 1'b0;
    end else if (m_after_br) begin
      e.busy = 1'b1; e.st = 2'd3; m_after_br = 1'b0;
    end else begin
      hz = ld && wreg && (rd != 0) &&
           ((rs1_en && rs1 == rd) || (rs2_en && rs2 == rd));
      if (br) begin
        e.fl_if_id = 1'b1; e.fl_id_exe = 1'b1; m_after_br = 1'b1;
      end else if (mc) begin
        n = (cyc == 0) ? 1 : int'(cyc);
        e.stall = 6'b001111;
        m_mc_left = n - 1;
      end else if (hz) begin
        e.stall = 6'b000011; e.fl_id_exe = 1'b1; m_after_lu = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic apply(
    input logic rs1_en, input logic [4:0] rs1, input logic rs2_en, input logic [4:0] rs2,
    input logic wreg, input logic [4:0] rd, input logic ld, input logic mc,
    input logic [MC_CNT_W-1:0] cyc, input logic br);
    @(posedge clk);
    #1;
    id_rs1_en_i = rs1_en; id_rs1_addr_i = rs1;
    id_rs2_en_i = rs2_en; id_rs2_addr_i = rs2;
    ex_wreg_i = wreg; ex_rd_addr_i = rd; ex_is_load_i = ld;
    ex_mc_start_i = mc; ex_mc_cycles_i = cyc; ex_branch_taken_i = br;
    sb_q.push_back(model_step(rs1_en, rs1, rs2_en, rs2, wreg, rd, ld, mc, cyc, br));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  resp_t mon_exp, mon_act;
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        mon_act = {stall_o, flush_if_id_o, flush_id_exe_o, busy_o, state_o};
        check("cycle_resp", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  initial begin
    // Reset state while rst is held
    #7;
    check("rst_stall",  32'(stall_o), 32'(0));
    check("rst_flush",  32'({flush_if_id_o, flush_id_exe_o}), 32'(0));
    check("rst_busy",   32'(busy_o), 32'(0));
    check("rst_state",  32'(state_o), 32'(0));
    #6 rst = 1'b0;
    model_reset();

    // Load-use on rs1, then dead cycle, then RUN
    apply(1, 5, 0, 0, 1, 5, 1, 0, 0, 0);
    idle(2);
    // Load-use on rs2
    apply(0, 0, 1, 9, 1, 9, 1, 0, 0, 0);
    idle(2);
    // x0 never hazards; disabled rs2 never hazards; non-load never hazards
    apply(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 7, 1, 7, 1, 0, 0, 0);
    apply(1, 3, 0, 0, 1, 3, 0, 0, 0, 0);
    apply(1, 3, 0, 0, 0, 3, 1, 0, 0, 0);
    // Multi-cycle of 4, then 0 and 1 (single stall cycle each)
    apply(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    idle(4);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(1);
    // Maximum length
    apply(0, 0, 0, 0, 0, 0, 0, 1, 63, 0);
    idle(64);
    // Priority: branch + mc + load-use together, then load-use in FLUSH cycle
    apply(1, 6, 0, 0, 1, 6, 1, 1, 5, 1);
    apply(1, 6, 0, 0, 1, 6, 1, 0, 0, 0);
    idle(1);
    // mc beats load-use
    apply(1, 6, 0, 0, 1, 6, 1, 1, 2, 0);
    idle(2);

    // Async reset in the middle of MC_WAIT with counter = 10
    apply(0, 0, 0, 0, 0, 0, 0, 1, 11, 0);
    @(posedge clk);
    #1;
    id_rs1_en_i = 1'b0; id_rs2_en_i = 1'b0; ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
    ex_mc_start_i = 1'b0; ex_mc_cycles_i = '0; ex_branch_taken_i = 1'b0;
    #1;
    check("mcw_stall_pre_rst", 32'(stall_o), 32'(6'b001111));
    check("mcw_state_pre_rst", 32'(state_o), 32'(2));
    #1 rst = 1'b1;
    #1;
    check("arst_stall", 32'(stall_o), 32'(0));
    check("arst_busy",  32'(busy_o), 32'(0));
    check("arst_state", 32'(state_o), 32'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check("post_rst_state", 32'(state_o), 32'(0));
    check("post_rst_stall", 32'(stall_o), 32'(0));
    apply(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    idle(3);

    // Randomized traffic with small register space to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      logic [MC_CNT_W-1:0] cyc;
      cyc = ($urandom_range(0, 9) == 0) ? MC_CNT_W'($urandom_range(0, 63))
                                        : MC_CNT_W'($urandom_range(0, 6));
      apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), cyc,
            ($urandom_range(0, 9) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB). It takes the decoded register-read requests of the instruction in ID and the destination/type of the instruction in EXE. From these it produces per-stage stall enables and bubble/flush strobes for load-use hazards, multi-cycle EXE operations and taken branches. It is the single source of stall/flush for all pipeline registers.

Parameters:
STALL_W, 6, width of stall vector (bit0 PC, bit1 IF/ID, bit2 ID/EXE, bit3 EXE/MEM, bit4 MEM/WB, bit5 reserved, always 0)
MC_CNT_W, 6, width of multi-cycle length field and internal down-counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1_en_i  in  1  ID reads rs1
id_rs1_addr_i  in  5  ID rs1 address
id_rs2_en_i  in  1  ID reads rs2
id_rs2_addr_i  in  5  ID rs2 address
ex_wreg_i  in  1  EXE instruction writes rd
ex_rd_addr_i  in  5  EXE destination register
ex_is_load_i  in  1  EXE instruction is a load
ex_mc_start_i  in  1  EXE starts multi-cycle op (1-cycle pulse)
ex_mc_cycles_i  in  MC_CNT_W  total cycles EXE is occupied
ex_branch_taken_i  in  1  EXE resolved a taken branch/jump
stall_o  out  STALL_W  per-stage hold enables (1 = hold)
flush_if_id_o  out  1  load NOP into IF/ID
flush_id_exe_o  out  1  load NOP into ID/EXE
busy_o  out  1  state != RUN
state_o  out  2  current state (debug)

Behaviour:
- Clock/reset: one clock (clk); rst asynchronous, active-high. While rst=1: state=RUN, counter=0, all outputs 0 (overrides combinational terms).
- States: RUN=0, LU_STALL=1, MC_WAIT=2, FLUSH=3. state_o = encoding; busy_o = (state!=RUN).
- lu_hazard = ex_is_load_i & ex_wreg_i & (ex_rd_addr_i!=0) & ((id_rs1_en_i & rs1==rd) | (id_rs2_en_i & rs2==rd)). x0 never hazards.
- Outputs are combinational from state and current inputs (same-cycle response, 0-cycle latency). State and counter are registered.
- RUN, evaluated in priority order:
  - branch_taken (highest): flush_if_id_o=1, flush_id_exe_o=1, stall_o=0, next=FLUSH.
  - else mc_start: N = ex_mc_cycles_i (N=0 treated as 1). stall_o=6'b001111. If N==1, next=RUN; else counter<=N-1 (N-1 being the remaining stall cycles, so the start cycle plus N-1 cycles gives N total), next=MC_WAIT.
  - else lu_hazard: stall_o=6'b000011 (hold PC, IF/ID), flush_id_exe_o=1 (bubble into EXE), next=LU_STALL.
  - else: all outputs 0.
- LU_STALL: exactly 1 cycle. Outputs 0; hazard detection suppressed (load now in MEM). next=RUN.
- MC_WAIT: stall_o=6'b001111, counter decrements each cycle. When counter==1 in MC_WAIT, next=RUN. Total stalled cycles = N exactly. All ex_* and id_* inputs are ignored (EXE is frozen). branch_taken cannot arrive (EXE held).
- FLUSH: 1 cycle. Outputs 0; lu_hazard suppressed (ID holds a bubble). next=RUN.
- Simultaneous events in RUN: branch > mc_start > load-use. The lower-priority event is dropped; it is re-evaluated when the instruction reaches the same point again.
- Reset mid-MC_WAIT/LU_STALL: immediate return to RUN, counter cleared, outputs 0 while asserted.
- Counter width MC_CNT_W: maximum N = 2^MC_CNT_W-1. No wrap, because the counter only decrements from N-1 ≥ 1 down to 1.

Decomposition:
- Shared define file: state encodings, stall bit indices (STALL_PC..STALL_WB), StallBus width, ZeroStall constant, reuse of RstEnable/ZeroRegAddr.
- One natural sub-module: hazard_detect (combinational lu_hazard compare). The FSM and counter stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: EXE load rd=5, ex_wreg=1; ID rs1_en=1 rs1=5 -> same cycle stall_o=000011, flush_id_exe_o=1; next cycle state=LU_STALL, outputs 0; then RUN.
- x0/disabled: EXE load rd=0 with rs1=0, and rd=7 with rs2=7 but rs2_en=0 -> no stall, no flush, state stays RUN.
- Multi-cycle: mc_start with cycles=4 -> stall_o=001111 for exactly 4 consecutive cycles, busy_o=1 on cycles 2-4; cycles=0 and cycles=1 -> exactly 1 stall cycle, state stays RUN.
- Priority: branch_taken + mc_start + lu_hazard in the same cycle -> flush_if_id=flush_id_exe=1, stall_o=0, next=FLUSH; lu_hazard in the FLUSH cycle -> ignored.
- Async reset: assert rst mid-MC_WAIT (counter=10) between clock edges -> outputs 0 immediately, state_o=0 after release, next mc_start behaves normally.
